mod_w_sched: RTL and testbench
==============================

Name: mod_w_sched

Overview:
- SHA-256 message-schedule writer.
- Accepts one 512-bit block as 16 words over a valid/ready stream and writes W[0..15] into MOD_W_MEM.
- Expands W[16..63] on the fly and writes each word into MOD_W_MEM.
- It is the write side of the W memory that MOD_COMPRESSOR reads by WI. DONE tells the round controller that all 64 words are valid.

Parameters:
- WORD_W, 32, message/schedule word width (fixed by SHA-256; not to be overridden)
- N_WORDS, 64, schedule length (addresses 0..N_WORDS-1)
- N_BLK, 16, input words per block

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous and active-high
- START  input  1  begin a new block; sampled only in IDLE
- M_IN  input  32  message word, big-endian word order (word 0 first)
- M_VALID  input  1  M_IN valid
- M_READY  output  1  block accepts M_IN this cycle
- WE  output  1  W memory write enable
- WA  output  6  W memory write address
- WD  output  32  W memory write data
- BUSY  output  1  high in LOAD and EXPAND
- DONE  output  1  one-cycle pulse: W[0..63] fully written

Behaviour:
- Reset (async, RST=1): state=IDLE, counter=0, window cleared to 0. All outputs read 0 (M_READY, WE, WA, WD, BUSY, DONE) while RST is high and after release.
- States: IDLE, LOAD, EXPAND, FIN.
- IDLE:
  - START=1 -> LOAD next edge, counter t=0.
  - Otherwise stay in IDLE.
- LOAD:
  - M_READY=1 (combinational from state).
  - Accept = M_VALID & M_READY.
  - On accept:
    - window shifts in M_IN (w[15] newest, w[0] oldest).
    - Registered WE=1, WA=t, WD=M_IN appear the following cycle.
    - t increments.
  - No accept -> WE=0 next cycle, nothing changes; gaps of any length are allowed.
  - Accept at t=15 -> EXPAND, t=16.
- EXPAND: one word per cycle, no stalls.
  - W[t] = s1(w[14]) + w[9] + s0(w[1]) + w[0], mod 2^32 (carries discarded).
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - Each cycle: registered WE=1, WA=t, WD=W[t]; window shifts in W[t]; t increments.
  - After t=63 -> FIN.
- FIN: DONE=1 for exactly one cycle, aligned with the cycle where the WA=63 write is presented. Then IDLE.
- Latency:
  - 16 accepted words -> first expanded write 1 cycle after the last LOAD write.
  - DONE 49 cycles after the 16th accept.
  - With M_VALID held high: START to DONE = 66 cycles.
- BUSY is high in LOAD and EXPAND, low in IDLE and FIN.
- START while not in IDLE is ignored (no restart, no error). START in FIN is ignored. START in IDLE in the cycle after FIN is honoured.
- M_VALID outside LOAD: ignored, M_READY=0, no write.
- Addresses never exceed 63; WA never wraps within a block.
- RST mid-LOAD or mid-EXPAND: immediate abort to IDLE. Partial W memory contents are undefined for the consumer. No DONE is emitted.

Decomposition:
- Shared package/header (sha256_defs): WORD_W, N_WORDS, N_BLK, state encodings, and the rotation amounts for s0/s1 (7, 18, 3 / 17, 19, 10). Reused later by the compressor's S0/S1/Ch/Maj.
- One sub-module: mod_sigma_small, purely combinational. Computes s0 and s1 of a 32-bit word, selected by a parameter. Instantiated twice.
- FSM, counter and 16×32 shift window stay in mod_w_sched.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), M_VALID held high -> 64 writes, WA 0..63 in order, no gaps after the first. Writes include WA=16 WD=0x61626380 and WA=17 WD=0x000F0000. DONE pulse together with the WA=63 write, 66 cycles after START.
- All-zero block -> all 64 writes carry WD=0. BUSY high through LOAD/EXPAND. One DONE.
- Backpressure: M_VALID toggles 1,0,0,1,… over the "abc" block -> WE only on the cycle after each accept, written data identical to the first test, DONE still 49 cycles after the 16th accept.
- Reset mid-EXPAND: RST at t=30 -> WE, BUSY and DONE drop to 0 immediately, no DONE emitted. A subsequent "abc" run reproduces the first test exactly.
- START pulses in LOAD, EXPAND and FIN -> no effect on the write sequence. Exactly one DONE per START issued in IDLE.
- Back-to-back blocks: START in the cycle after FIN with a second block -> second 64-write sequence correct, no stale window words from the first block.

Source files
------------

// File: rtl/mod_w_sched_pkg.sv
// Shared SHA-256 definitions: word geometry, schedule FSM states and the
// small-sigma rotation amounts, reused later by the compressor datapath.
package mod_w_sched_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 64;
  localparam int N_BLK   = 16;
  localparam int ADDR_W  = $clog2(N_WORDS);

  // Small-sigma rotation/shift amounts: s0 = (7, 18, >>3), s1 = (17, 19, >>10)
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_FIN    = 2'd3
  } sched_state_e;

  // Rotate a word right by n bit positions (0 < n < WORD_W)
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/mod_w_sched_if.sv
// Stream-in / memory-write bundle of the message-schedule writer.
// The master side supplies START and message words; the slave side (the
// scheduler) returns the ready flag, the W-memory write port and status.
interface mod_w_sched_if;
  import mod_w_sched_pkg::*;

  logic  start;
  word_t mIn;
  logic  mValid;
  logic  mReady;
  logic  we;
  addr_t wa;
  word_t wd;
  logic  busy;
  logic  done;

  modport master (
    output start, mIn, mValid,
    input  mReady, we, wa, wd, busy, done
  );

  modport slave (
    input  start, mIn, mValid,
    output mReady, we, wa, wd, busy, done
  );

endinterface

// File: rtl/mod_w_sched_sigma_small.sv
// Combinational SHA-256 small sigma. SEL_S1=0 gives s0, SEL_S1=1 gives s1.
module mod_sigma_small
  import mod_w_sched_pkg::*;
#(
  parameter bit SEL_S1 = 1'b0
) (
  input  word_t x_i,
  output word_t y_o
);

  localparam int unsigned ROT_A = SEL_S1 ? S1_ROT_A : S0_ROT_A;
  localparam int unsigned ROT_B = SEL_S1 ? S1_ROT_B : S0_ROT_B;
  localparam int unsigned SHR_N = SEL_S1 ? S1_SHR   : S0_SHR;

  assign y_o = rotr(x_i, ROT_A) ^ rotr(x_i, ROT_B) ^ (x_i >> SHR_N);

endmodule

// File: rtl/mod_w_sched.sv
// SHA-256 message-schedule writer. Loads 16 message words into a sliding
// window, writes them to W memory, then expands W[16..63] one per cycle.
// DONE pulses alongside the final (WA=63) write.
module mod_w_sched
  import mod_w_sched_pkg::*;
(
  input logic          clk,
  input logic          rst,
  mod_w_sched_if.slave schedBus
);

  sched_state_e state_q, state_d;
  addr_t        tCount_q, tCount_d;
  word_t        window_q [N_BLK];
  word_t        window_d [N_BLK];
  logic         wrEn_q, wrEn_d;
  addr_t        wrAddr_q, wrAddr_d;
  word_t        wrData_q, wrData_d;
  logic         done_q, done_d;

  word_t sig0;
  word_t sig1;
  word_t expWord;
  logic  accept;

  // window[1] holds W[t-15], window[14] holds W[t-2]
  mod_sigma_small #(.SEL_S1(1'b0)) uSig0 (.x_i(window_q[1]),  .y_o(sig0));
  mod_sigma_small #(.SEL_S1(1'b1)) uSig1 (.x_i(window_q[14]), .y_o(sig1));

  assign expWord = sig1 + window_q[9] + sig0 + window_q[0];

  assign accept          = (state_q == ST_LOAD) && schedBus.mValid;
  assign schedBus.mReady = (state_q == ST_LOAD);
  assign schedBus.busy   = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
  assign schedBus.we     = wrEn_q;
  assign schedBus.wa     = wrAddr_q;
  assign schedBus.wd     = wrData_q;
  assign schedBus.done   = done_q;

  // Next-state logic: sequencing, window shift and the next write request
  always_comb begin
    state_d  = state_q;
    tCount_d = tCount_q;
    window_d = window_q;
    wrEn_d   = 1'b0;
    wrAddr_d = '0;
    wrData_d = '0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (schedBus.start) begin
          state_d  = ST_LOAD;
          tCount_d = '0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          for (int i = 0; i < N_BLK - 1; i++) window_d[i] = window_q[i+1];
          window_d[N_BLK-1] = schedBus.mIn;
          wrEn_d   = 1'b1;
          wrAddr_d = tCount_q;
          wrData_d = schedBus.mIn;
          tCount_d = tCount_q + 1'b1;
          if (tCount_q == addr_t'(N_BLK - 1)) state_d = ST_EXPAND;
        end
      end

      ST_EXPAND: begin
        for (int i = 0; i < N_BLK - 1; i++) window_d[i] = window_q[i+1];
        window_d[N_BLK-1] = expWord;
        wrEn_d   = 1'b1;
        wrAddr_d = tCount_q;
        wrData_d = expWord;
        tCount_d = tCount_q + 1'b1;
        if (tCount_q == addr_t'(N_WORDS - 1)) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, window and registered write/done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tCount_q <= '0;
      for (int i = 0; i < N_BLK; i++) window_q[i] <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tCount_q <= tCount_d;
      for (int i = 0; i < N_BLK; i++) window_q[i] <= window_d[i];
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mod_w_sched.sv
// Self-checking bench for mod_w_sched: a fixed-vector table for the "abc"
// block, hand-written corner sequences, and random blocks compared against
// a direct SHA-256 message-schedule model.
module tb_mod_w_sched;
  import mod_w_sched_pkg::*;

  typedef logic [31:0] blk_t [16];
  typedef logic [31:0] sched_t [64];

  typedef struct {
    int          cyc;
    logic [5:0]  wa;
    logic [31:0] wd;
  } wr_rec_t;

  typedef struct {
    string       name;
    int          addr;
    logic [31:0] wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  mod_w_sched_if bus();

  mod_w_sched dut (
    .clk      (clk),
    .rst      (rst),
    .schedBus (bus)
  );

  always #5 clk = ~clk;

  wr_rec_t wrLog[$];
  int      doneLog[$];
  int      accLog[$];
  int      busyCount = 0;
  int      cyc = 0;

  int errCount   = 0;
  int checkCount = 0;

  // Mid-cycle monitor: log writes, DONE pulses, accepts and BUSY cycles
  always @(negedge clk) begin
    wr_rec_t r;
    cyc = cyc + 1;
    if (bus.we === 1'b1) begin
      r.cyc = cyc;
      r.wa  = bus.wa;
      r.wd  = bus.wd;
      wrLog.push_back(r);
    end
    if (bus.done === 1'b1) doneLog.push_back(cyc);
    if (bus.mValid === 1'b1 && bus.mReady === 1'b1) accLog.push_back(cyc);
    if (bus.busy === 1'b1) busyCount = busyCount + 1;
  end

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  // Textbook SHA-256 schedule recurrence over the full 64-entry array
  function automatic void refSchedule(input blk_t m, output sched_t w);
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checkCount = checkCount + 1;
    if (act != exp) begin
      errCount = errCount + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " WE"},     longint'(bus.we),     0);
    checkOutput({tag, " WA"},     longint'(bus.wa),     0);
    checkOutput({tag, " WD"},     longint'(bus.wd),     0);
    checkOutput({tag, " BUSY"},   longint'(bus.busy),   0);
    checkOutput({tag, " DONE"},   longint'(bus.done),   0);
    checkOutput({tag, " MREADY"}, longint'(bus.mReady), 0);
  endtask

  task automatic clearLogs();
    wrLog.delete();
    doneLog.delete();
    accLog.delete();
    busyCount = 0;
  endtask

  // Issue START, stream a block with the chosen valid pattern
  // (0 held high, 1 pattern 1,0,0, 2 random) and wait for DONE.
  task automatic applyStimulus(input blk_t m, input int vmode, input bit junkStarts,
                               output int startCyc);
    int idx;
    int k;
    bit v;
    bit acc;
    bit gotDone;
    clearLogs();
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.mValid = 1'b1;
    bus.mIn    = $urandom;
    startCyc   = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0;
    k   = 0;
    while (idx < 16 && k < 400) begin
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = (k % 3 == 0);
      else                 v = ($urandom_range(0, 2) != 0);
      bus.mValid = v;
      bus.mIn    = v ? m[idx] : $urandom;
      if (junkStarts) bus.start = (k == 2 || k == 5);
      @(negedge clk);
      acc = bus.mValid && bus.mReady;
      @(posedge clk); #1;
      if (acc) idx++;
      k++;
    end
    if (idx < 16) checkOutput("load timeout words", idx, 16);
    bus.mValid = 1'b1;
    bus.mIn    = $urandom;
    bus.start  = junkStarts;
    gotDone    = 1'b0;
    k          = 0;
    while (!gotDone && k < 200) begin
      if (k == 8) bus.start = 1'b0;
      @(negedge clk); #1;
      if (bus.done === 1'b1) gotDone = 1'b1;
      else k++;
    end
    if (!gotDone) checkOutput("done timeout", 0, 1);
    bus.mValid = 1'b0;
    if (gotDone && junkStarts) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic settle(input string tag);
    repeat (5) @(negedge clk);
    #1;
    checkOutput({tag, " idle after block"}, longint'(bus.busy), 0);
  endtask

  task automatic checkBlock(input blk_t m, input int startCyc, input bit heldHigh,
                            input string tag);
    sched_t exp;
    int bad;
    int want;
    refSchedule(m, exp);
    checkOutput({tag, " write count"},  wrLog.size(),   64);
    checkOutput({tag, " accept count"}, accLog.size(),  16);
    checkOutput({tag, " done count"},   doneLog.size(), 1);
    for (int i = 0; i < 64; i++) begin
      if (i < wrLog.size())
        checkOutput($sformatf("%s W[%0d] addr/data", tag, i),
                    longint'({wrLog[i].wa, wrLog[i].wd}),
                    longint'({i[5:0], exp[i]}));
    end
    if (wrLog.size() == 64 && accLog.size() == 16) begin
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        want = (i < 16) ? accLog[i] + 1 : wrLog[i-1].cyc + 1;
        if (wrLog[i].cyc != want) bad++;
      end
      checkOutput({tag, " write timing errors"}, bad, 0);
      if (doneLog.size() > 0) begin
        checkOutput({tag, " DONE with WA=63"}, doneLog[0], wrLog[63].cyc);
        checkOutput({tag, " 16th accept to DONE"}, doneLog[0] - accLog[15], 49);
        if (heldHigh)
          checkOutput({tag, " START to DONE cycles"}, doneLog[0] - startCyc + 1, 66);
        checkOutput({tag, " BUSY cycles"}, busyCount, doneLog[0] - startCyc - 1);
      end
    end
  endtask

  task automatic checkAbcTable(input vec_t vecs[5], input string tag);
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].addr < wrLog.size())
        checkOutput({tag, " ", vecs[i].name}, longint'(wrLog[vecs[i].addr].wd),
                    longint'(vecs[i].wd));
      else
        checkOutput({tag, " ", vecs[i].name, " missing"}, wrLog.size(), vecs[i].addr + 1);
    end
  endtask

  initial begin
    blk_t abcBlk;
    blk_t zeroBlk;
    blk_t rndBlk;
    vec_t abcVecs[5];
    int   sCyc;
    int   nWr;

    for (int i = 0; i < 16; i++) begin
      abcBlk[i]  = 32'h0;
      zeroBlk[i] = 32'h0;
    end
    abcBlk[0]  = 32'h61626380;
    abcBlk[15] = 32'h00000018;

    abcVecs[0] = '{"abc W0",  0,  32'h61626380};
    abcVecs[1] = '{"abc W1",  1,  32'h00000000};
    abcVecs[2] = '{"abc W15", 15, 32'h00000018};
    abcVecs[3] = '{"abc W16", 16, 32'h61626380};
    abcVecs[4] = '{"abc W17", 17, 32'h000F0000};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.mValid = 1'b1;
    bus.mIn    = 32'hDEADBEEF;

    #1;
    checkAllZero("in reset");
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checkAllZero("after reset");

    $display("[TB] IDLE ignores M_VALID");
    clearLogs();
    repeat (10) begin
      @(posedge clk); #1;
      bus.mIn = $urandom;
    end
    bus.mValid = 1'b0;
    checkOutput("idle no writes", wrLog.size(), 0);

    $display("[TB] abc block, M_VALID held high");
    applyStimulus(abcBlk, 0, 1'b0, sCyc);
    settle("abc");
    checkBlock(abcBlk, sCyc, 1'b1, "abc");
    checkAbcTable(abcVecs, "abc");

    $display("[TB] all-zero block");
    applyStimulus(zeroBlk, 0, 1'b0, sCyc);
    settle("zero");
    checkBlock(zeroBlk, sCyc, 1'b1, "zero");

    $display("[TB] abc block with backpressure 1,0,0");
    applyStimulus(abcBlk, 1, 1'b0, sCyc);
    settle("bp");
    checkBlock(abcBlk, sCyc, 1'b0, "bp");
    checkAbcTable(abcVecs, "bp");

    $display("[TB] reset in mid-EXPAND");
    clearLogs();
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.mValid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.mValid = 1'b1;
      bus.mIn    = abcBlk[i];
      @(posedge clk); #1;
    end
    bus.mIn = $urandom;
    repeat (14) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("writes before reset", wrLog.size(), 30);
    rst = 1'b1;
    #1;
    checkAllZero("mid-expand reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    nWr = wrLog.size();
    repeat (80) @(posedge clk);
    bus.mValid = 1'b0;
    checkOutput("no writes after abort", wrLog.size(), nWr);
    checkOutput("no DONE after abort", doneLog.size(), 0);

    applyStimulus(abcBlk, 0, 1'b0, sCyc);
    settle("abc rerun");
    checkBlock(abcBlk, sCyc, 1'b1, "abc rerun");
    checkAbcTable(abcVecs, "abc rerun");

    $display("[TB] START pulses in LOAD, EXPAND and FIN");
    applyStimulus(abcBlk, 0, 1'b1, sCyc);
    settle("junk start");
    checkBlock(abcBlk, sCyc, 1'b1, "junk start");

    $display("[TB] back-to-back blocks");
    for (int i = 0; i < 16; i++) rndBlk[i] = $urandom;
    applyStimulus(rndBlk, 0, 1'b0, sCyc);
    checkBlock(rndBlk, sCyc, 1'b1, "b2b first");
    applyStimulus(abcBlk, 0, 1'b0, sCyc);
    settle("b2b second");
    checkBlock(abcBlk, sCyc, 1'b1, "b2b second");
    checkAbcTable(abcVecs, "b2b second");

    $display("[TB] random blocks with random M_VALID");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) rndBlk[i] = $urandom;
      applyStimulus(rndBlk, 2, (r == 1), sCyc);
      settle($sformatf("rnd%0d", r));
      checkBlock(rndBlk, sCyc, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
